box_compositor: RTL
===================

BOX_COMPOSITOR -- requirements
Module: box_compositor

Interface
REQ-001 SHALL have parameter NUM_BOXES, default 8, number of rectangle objects (1..16).
REQ-002 SHALL have parameter COORD_W, default 10, pixel coordinate width.
REQ-003 SHALL have parameter COLOR_W, default 12, pixel color width (R, G, B nibbles).
REQ-004 SHALL have parameter BG_COLOR, default 12'h000, background color.
REQ-005 SHALL have port CLK_50  in  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port pix_en  in  1  one-cycle strobe per pixel; pipeline advances only when high.
REQ-008 SHALL have port X_pix, Y_pix  in  COORD_W each  current raster coordinate.
REQ-009 SHALL have port visible  in  1  raster inside active area.
REQ-010 SHALL have port frame_start  in  1  one-cycle pulse at start of vertical blank.
REQ-011 SHALL have port wr_en  in  1  object write strobe.
REQ-012 SHALL have port wr_idx  in  clog2(NUM_BOXES)  object index.
REQ-013 SHALL have ports wr_x, wr_y, wr_w, wr_h  in  COORD_W each  object geometry.
REQ-014 SHALL have port wr_color  in  COLOR_W  object color.
REQ-015 SHALL have port wr_on  in  1  object enable.
REQ-016 SHALL have port pixel_color  out  COLOR_W  composited pixel.
REQ-017 SHALL have port hit_mask  out  NUM_BOXES  objects covering the current output pixel.
REQ-018 SHALL have port collide  out  NUM_BOXES  per-object overlap flags of the previous frame.

Function
REQ-019 A write with wr_en high SHALL update the shadow record of object wr_idx in one cycle; wr_idx >= NUM_BOXES SHALL be ignored.
REQ-020 On frame_start all shadow records SHALL copy to the active records; a same-cycle write SHALL land in shadow only, becoming active at the next frame_start.
REQ-021 Hit test SHALL be X_pix >= x, X_pix < x+w, Y_pix >= y, Y_pix < y+h, computed at COORD_W+1 bits so no wrap occurs.
REQ-022 w = 0 or h = 0, or on = 0, SHALL never hit.
REQ-023 Stage 1 (pix_en) SHALL register hit vector; stage 2 (pix_en) SHALL register pixel_color and hit_mask: latency exactly 2 pix_en strobes.
REQ-024 Color priority: lowest-index hitting object wins; no hit or visible=0 SHALL output BG_COLOR and hit_mask = 0.
REQ-025 Outputs SHALL hold when pix_en low.
REQ-026 Any stage-2 pixel with two or more hits SHALL set sticky accumulator bits for every hitting object.
REQ-027 On frame_start, collide SHALL load the accumulator and the accumulator SHALL clear in the same cycle; a hit in that cycle SHALL go into the new accumulator.
REQ-028 frame_start SHALL NOT flush the pixel pipeline.

Reset
REQ-029 reset_n low SHALL asynchronously clear all shadow and active records (on = 0, geometry 0, color 0), pipeline, accumulator and collide.
REQ-030 During and after reset until first write, pixel_color SHALL equal BG_COLOR and hit_mask = 0.
REQ-031 Release SHALL be deassertion-synchronised by the instantiating top; the block does no internal synchronisation.

Structure
REQ-032 Shared package SHALL hold the object record type (x, y, w, h, color, on) and default COORD_W/COLOR_W constants.
REQ-033 One sub-module box_hit (combinational per-object hit test, REQ-021/022) SHALL be instantiated NUM_BOXES times via generate.
REQ-034 Priority encoder and collision accumulator SHALL stay in box_compositor.

Verification
REQ-035 Write obj0 x=20,y=100,w=10,h=120,color=FFF,on; frame_start; raster (20,100) -> FFF two strobes later; (30,100) -> BG; (19,100) -> BG.
REQ-036 obj0 color F00 and obj1 color 0F0 both at (50,50,10,10); pixel (55,55) -> F00, hit_mask=2'b11; next frame_start -> collide=2'b11.
REQ-037 Write obj2 mid-frame -> no effect until frame_start; write same cycle as frame_start -> visible only after the following frame_start.
REQ-038 obj x=1020,w=10 (COORD_W=10) -> X_pix 0..5 never hits (no wrap); w=0 -> never hits.
REQ-039 Assert reset_n low mid-line with objects active -> pixel_color=BG, hit_mask=0, collide=0 immediately; objects off after release.
REQ-040 pix_en held low 5 cycles -> outputs unchanged; visible=0 over an object -> BG.

Source files
------------

// File: rtl/box_compositor_pkg.sv
// ---------------------------------------------------------------------------
// box_compositor_pkg
// Shared constants and the object record type for the box compositor.
// A record describes one rectangle: top-left (x, y), size (w, h), a color
// and an enable bit. Record fields are sized by the default widths below.
// ---------------------------------------------------------------------------
package box_compositor_pkg;

  localparam int COORD_W_DEF = 10;  // pixel coordinate width
  localparam int COLOR_W_DEF = 12;  // 4-bit R, G, B

  typedef struct packed {
    logic [COORD_W_DEF-1:0] x;
    logic [COORD_W_DEF-1:0] y;
    logic [COORD_W_DEF-1:0] w;
    logic [COORD_W_DEF-1:0] h;
    logic [COLOR_W_DEF-1:0] color;
    logic                   on;
  } box_rec_t;

  // True when two or more bits of v are set (v & (v-1) drops the lowest one).
  function automatic logic multi_hot(input logic [15:0] v);
    return (v & (v - 16'd1)) != 16'd0;
  endfunction

endpackage

// File: rtl/box_hit.sv
// ---------------------------------------------------------------------------
// box_hit
// Combinational hit test of one raster coordinate against one rectangle.
// Ports:
//   i_x_pix, i_y_pix : current raster coordinate
//   i_x, i_y         : rectangle top-left corner
//   i_w, i_h         : rectangle size (0 in either never hits)
//   i_on             : rectangle enable
//   o_hit            : coordinate lies inside the enabled rectangle
// ---------------------------------------------------------------------------
module box_hit #(
  parameter int COORD_W = 10
) (
  input  logic [COORD_W-1:0] i_x_pix,
  input  logic [COORD_W-1:0] i_y_pix,
  input  logic [COORD_W-1:0] i_x,
  input  logic [COORD_W-1:0] i_y,
  input  logic [COORD_W-1:0] i_w,
  input  logic [COORD_W-1:0] i_h,
  input  logic               i_on,
  output logic               o_hit
);

  // One extra bit on the far edges so a box hanging off the right/bottom of
  // the coordinate space does not wrap around onto the left/top.
  logic [COORD_W:0] w_x_end;
  logic [COORD_W:0] w_y_end;
  logic             w_in_x;
  logic             w_in_y;

  assign w_x_end = {1'b0, i_x} + {1'b0, i_w};
  assign w_y_end = {1'b0, i_y} + {1'b0, i_h};

  assign w_in_x = (i_x_pix >= i_x) && ({1'b0, i_x_pix} < w_x_end);
  assign w_in_y = (i_y_pix >= i_y) && ({1'b0, i_y_pix} < w_y_end);

  assign o_hit = i_on && (i_w != '0) && (i_h != '0) && w_in_x && w_in_y;

endmodule

// File: rtl/box_compositor.sv
// ---------------------------------------------------------------------------
// box_compositor
// Overlays up to NUM_BOXES colored rectangles on a raster stream.
// Objects are written into shadow records at any time and become active
// together at frame_start. Each pixel passes a two-stage pipeline
// (hit vector, then priority color) that advances only on pix_en.
// Pixels covered by two or more objects flag those objects in a sticky
// accumulator, which is published on collide at every frame_start.
// Ports:
//   CLK_50, reset_n          : clock, async active-low reset
//   pix_en                   : pixel strobe, advances the pipeline
//   X_pix, Y_pix, visible    : raster coordinate and active-area flag
//   frame_start              : start of vertical blank
//   wr_en, wr_idx, wr_x/y/w/h, wr_color, wr_on : object write port
//   pixel_color, hit_mask    : composited pixel, two strobes after input
//   collide                  : objects that overlapped during last frame
// Geometry/color are stored in the package record type, so COORD_W and
// COLOR_W are expected to match the package defaults.
// ---------------------------------------------------------------------------
module box_compositor
  import box_compositor_pkg::*;
#(
  parameter int                 NUM_BOXES = 8,
  parameter int                 COORD_W   = COORD_W_DEF,
  parameter int                 COLOR_W   = COLOR_W_DEF,
  parameter logic [COLOR_W-1:0] BG_COLOR  = '0,
  localparam int                IDX_W     = (NUM_BOXES > 1) ? $clog2(NUM_BOXES) : 1
) (
  input  logic                 CLK_50,
  input  logic                 reset_n,
  input  logic                 pix_en,
  input  logic [COORD_W-1:0]   X_pix,
  input  logic [COORD_W-1:0]   Y_pix,
  input  logic                 visible,
  input  logic                 frame_start,
  input  logic                 wr_en,
  input  logic [IDX_W-1:0]     wr_idx,
  input  logic [COORD_W-1:0]   wr_x,
  input  logic [COORD_W-1:0]   wr_y,
  input  logic [COORD_W-1:0]   wr_w,
  input  logic [COORD_W-1:0]   wr_h,
  input  logic [COLOR_W-1:0]   wr_color,
  input  logic                 wr_on,
  output logic [COLOR_W-1:0]   pixel_color,
  output logic [NUM_BOXES-1:0] hit_mask,
  output logic [NUM_BOXES-1:0] collide
);

  box_rec_t               r_shadow [NUM_BOXES];
  box_rec_t               r_active [NUM_BOXES];
  box_rec_t               w_wr_rec;
  logic                   w_wr_ok;
  logic [NUM_BOXES-1:0]   w_hit;
  logic [NUM_BOXES-1:0]   r_hit1;
  logic [COLOR_W-1:0]     w_color;
  logic [NUM_BOXES-1:0]   r_acc;
  logic [NUM_BOXES-1:0]   w_acc_next;

  // ---- object write port ---------------------------------------------------
  always_comb begin
    w_wr_rec       = '0;
    w_wr_rec.x     = COORD_W_DEF'(wr_x);
    w_wr_rec.y     = COORD_W_DEF'(wr_y);
    w_wr_rec.w     = COORD_W_DEF'(wr_w);
    w_wr_rec.h     = COORD_W_DEF'(wr_h);
    w_wr_rec.color = COLOR_W_DEF'(wr_color);
    w_wr_rec.on    = wr_on;
  end

  // Out-of-range indices (possible when NUM_BOXES is not a power of two)
  // are dropped.
  assign w_wr_ok = wr_en && ({1'b0, wr_idx} < (IDX_W+1)'(NUM_BOXES));

  // NOTE: the object records are a small register file, not a RAM, and must
  // power up disabled, so they sit on the async reset like any other flop.
  always_ff @(posedge CLK_50 or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_BOXES; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_BOXES; i++) begin
        // active takes the pre-write shadow, so a write coinciding with
        // frame_start waits for the following frame_start.
        if (frame_start) r_active[i] <= r_shadow[i];
        if (w_wr_ok && (wr_idx == IDX_W'(i))) r_shadow[i] <= w_wr_rec;
      end
    end
  end

  // ---- stage 0: per-object hit tests -----------------------------------------
  for (genvar g = 0; g < NUM_BOXES; g++) begin : g_hit
    box_hit #(.COORD_W(COORD_W)) u_box_hit (
      .i_x_pix (X_pix),
      .i_y_pix (Y_pix),
      .i_x     (COORD_W'(r_active[g].x)),
      .i_y     (COORD_W'(r_active[g].y)),
      .i_w     (COORD_W'(r_active[g].w)),
      .i_h     (COORD_W'(r_active[g].h)),
      .i_on    (r_active[g].on),
      .o_hit   (w_hit[g])
    );
  end

  // ---- stage 1: registered hit vector, blanked outside the active area ---------
  always_ff @(posedge CLK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_hit1 <= '0;
    end else if (pix_en) begin
      r_hit1 <= visible ? w_hit : '0;
    end
  end

  // ---- stage 2: priority color ---------------------------------------------
  // NOTE: w_color gets its default before the loop, so every path assigns it
  // and no latch is inferred. Walking from the highest index down with
  // blocking assignments leaves the lowest hitting index as the winner.
  always_comb begin
    w_color = BG_COLOR;
    for (int i = NUM_BOXES - 1; i >= 0; i--) begin
      if (r_hit1[i]) w_color = COLOR_W'(r_active[i].color);
    end
  end

  always_ff @(posedge CLK_50 or negedge reset_n) begin
    if (!reset_n) begin
      pixel_color <= BG_COLOR;
      hit_mask    <= '0;
    end else if (pix_en) begin
      pixel_color <= w_color;
      hit_mask    <= r_hit1;
    end
  end

  // ---- collision accumulator ------------------------------------------------
  // frame_start empties the accumulator, but a multi-hit pixel entering
  // stage 2 in that same cycle still lands in the fresh accumulator.
  always_comb begin
    w_acc_next = frame_start ? '0 : r_acc;
    if (pix_en && multi_hot(16'(r_hit1))) w_acc_next = w_acc_next | r_hit1;
  end

  always_ff @(posedge CLK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_acc   <= '0;
      collide <= '0;
    end else begin
      r_acc <= w_acc_next;
      if (frame_start) collide <= r_acc;
    end
  end

endmodule
